dand_riscv_simple: RTL and testbench

- Minimal in-order RV64I integer core, non-pipelined, multi-cycle FSM: fetch, wait, execute/memory, writeback.
- Talks to an instruction port and a data port using valid/ready command channels and valid response channels.
- Exposes a commit (retire) observation port for the difftest harness, which compares architectural state against a reference model.

---
 rtl/dand_riscv_simple_pkg.sv | 98 +++++++++
 rtl/dand_regfile.sv | 92 +++++++++
 rtl/dand_riscv_simple.sv | 233 +++++++++++++++++++++++
 tb/tb_dand_riscv_simple.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dand_riscv_simple_pkg.sv
// Shared types for the dand_riscv_simple RV64I core.
// Opcodes, FSM states, access sizes and datapath helper functions.
package dand_riscv_simple_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] OP_HALT   = 7'h6b;

  typedef enum logic [2:0] {
    FETCH, IWAIT, EXEC, WB, HALT
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // w selects the 32-bit *W form: 5-bit shamt, sign-extended result
  function automatic logic [63:0] alu_op(
    input logic [2:0]  f3,
    input logic        alt,
    input logic        w,
    input logic [63:0] a,
    input logic [63:0] b
  );
    logic [63:0] r;
    logic [31:0] rw;
    logic [5:0]  sh;
    sh = w ? {1'b0, b[4:0]} : b[5:0];
    r  = '0;
    rw = '0;
    case (f3)
      3'd0: r = alt ? a - b : a + b;
      3'd1: r = a << sh;
      3'd2: r = {63'b0, $signed(a) < $signed(b)};
      3'd3: r = {63'b0, a < b};
      3'd4: r = a ^ b;
      3'd5: begin
        if (w) begin
          if (alt) rw = $signed(a[31:0]) >>> sh[4:0];
          else     rw = a[31:0] >> sh[4:0];
          r = {32'b0, rw};
        end else if (alt) begin
          r = $signed(a) >>> sh;
        end else begin
          r = a >> sh;
        end
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    if (w) r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  function automatic logic [63:0] load_ext(
    input logic [63:0] d,
    input logic [2:0]  off,
    input logic [2:0]  f3
  );
    logic [63:0] s;
    s = d >> {off, 3'b000};
    case (f3[1:0])
      SZ_B: return f3[2] ? {56'b0, s[7:0]}
                         : {{56{s[7]}}, s[7:0]};
      SZ_H: return f3[2] ? {48'b0, s[15:0]}
                         : {{48{s[15]}}, s[15:0]};
      SZ_W: return f3[2] ? {32'b0, s[31:0]}
                         : {{32{s[31]}}, s[31:0]};
      default: return s;
    endcase
  endfunction

  // strobes pushed past lane 7 fall off the 8-bit result
  function automatic logic [7:0] lane_strb(
    input logic [1:0] sz,
    input logic [2:0] off
  );
    logic [7:0] m;
    case (sz)
      SZ_B: m = 8'h01;
      SZ_H: m = 8'h03;
      SZ_W: m = 8'h0f;
      default: m = 8'hff;
    endcase
    return m << off;
  endfunction

endpackage

// File: rtl/dand_regfile.sv
// 32 x 64-bit integer register file, x0 hardwired to zero.
// Ports: clk, reset, two async read ports, one write port.
module dand_regfile
  import dand_riscv_simple_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_addr,
  output logic [63:0] rs1_data,
  input  logic [4:0]  rs2_addr,
  output logic [63:0] rs2_data,
  input  logic        wen,
  input  logic [4:0]  waddr,
  input  logic [63:0] wdata
);

  logic [63:0] reg_file_0,  reg_file_1,  reg_file_2,  reg_file_3;
  logic [63:0] reg_file_4,  reg_file_5,  reg_file_6,  reg_file_7;
  logic [63:0] reg_file_8,  reg_file_9,  reg_file_10, reg_file_11;
  logic [63:0] reg_file_12, reg_file_13, reg_file_14, reg_file_15;
  logic [63:0] reg_file_16, reg_file_17, reg_file_18, reg_file_19;
  logic [63:0] reg_file_20, reg_file_21, reg_file_22, reg_file_23;
  logic [63:0] reg_file_24, reg_file_25, reg_file_26, reg_file_27;
  logic [63:0] reg_file_28, reg_file_29, reg_file_30, reg_file_31;

  logic [31:0][63:0] rf;

  assign reg_file_0 = '0;

  assign rf = {
    reg_file_31, reg_file_30, reg_file_29, reg_file_28,
    reg_file_27, reg_file_26, reg_file_25, reg_file_24,
    reg_file_23, reg_file_22, reg_file_21, reg_file_20,
    reg_file_19, reg_file_18, reg_file_17, reg_file_16,
    reg_file_15, reg_file_14, reg_file_13, reg_file_12,
    reg_file_11, reg_file_10, reg_file_9,  reg_file_8,
    reg_file_7,  reg_file_6,  reg_file_5,  reg_file_4,
    reg_file_3,  reg_file_2,  reg_file_1,  reg_file_0
  };

  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {reg_file_1,  reg_file_2,  reg_file_3,  reg_file_4,
       reg_file_5,  reg_file_6,  reg_file_7,  reg_file_8,
       reg_file_9,  reg_file_10, reg_file_11, reg_file_12,
       reg_file_13, reg_file_14, reg_file_15, reg_file_16,
       reg_file_17, reg_file_18, reg_file_19, reg_file_20,
       reg_file_21, reg_file_22, reg_file_23, reg_file_24,
       reg_file_25, reg_file_26, reg_file_27, reg_file_28,
       reg_file_29, reg_file_30, reg_file_31} <= '0;
    end else if (wen) begin
      case (waddr)
        5'd1:  reg_file_1  <= wdata;
        5'd2:  reg_file_2  <= wdata;
        5'd3:  reg_file_3  <= wdata;
        5'd4:  reg_file_4  <= wdata;
        5'd5:  reg_file_5  <= wdata;
        5'd6:  reg_file_6  <= wdata;
        5'd7:  reg_file_7  <= wdata;
        5'd8:  reg_file_8  <= wdata;
        5'd9:  reg_file_9  <= wdata;
        5'd10: reg_file_10 <= wdata;
        5'd11: reg_file_11 <= wdata;
        5'd12: reg_file_12 <= wdata;
        5'd13: reg_file_13 <= wdata;
        5'd14: reg_file_14 <= wdata;
        5'd15: reg_file_15 <= wdata;
        5'd16: reg_file_16 <= wdata;
        5'd17: reg_file_17 <= wdata;
        5'd18: reg_file_18 <= wdata;
        5'd19: reg_file_19 <= wdata;
        5'd20: reg_file_20 <= wdata;
        5'd21: reg_file_21 <= wdata;
        5'd22: reg_file_22 <= wdata;
        5'd23: reg_file_23 <= wdata;
        5'd24: reg_file_24 <= wdata;
        5'd25: reg_file_25 <= wdata;
        5'd26: reg_file_26 <= wdata;
        5'd27: reg_file_27 <= wdata;
        5'd28: reg_file_28 <= wdata;
        5'd29: reg_file_29 <= wdata;
        5'd30: reg_file_30 <= wdata;
        5'd31: reg_file_31 <= wdata;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dand_riscv_simple.sv
// Multi-cycle RV64I core: FETCH, IWAIT, EXEC, WB (+HALT).
// Ports: icache/dcache cmd+rsp channels, commit observation, halted.
module dand_riscv_simple
  import dand_riscv_simple_pkg::*;
#(
  parameter logic [63:0] PC_START    = 64'h8000_0000,
  parameter logic [6:0]  HALT_OPCODE = OP_HALT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        icache_cmd_valid,
  input  logic        icache_cmd_ready,
  output logic [63:0] icache_cmd_payload_addr,
  input  logic        icache_rsp_valid,
  input  logic [31:0] icache_rsp_payload_data,
  output logic        dcache_cmd_valid,
  input  logic        dcache_cmd_ready,
  output logic [63:0] dcache_cmd_payload_addr,
  output logic        dcache_cmd_payload_wen,
  output logic [63:0] dcache_cmd_payload_wdata,
  output logic [7:0]  dcache_cmd_payload_wstrb,
  output logic [2:0]  dcache_cmd_payload_size,
  input  logic        dcache_rsp_valid,
  input  logic [63:0] dcache_rsp_payload_data,
  output logic        commit_valid,
  output logic [63:0] commit_pc,
  output logic [31:0] commit_inst,
  output logic        commit_rd_wen,
  output logic [4:0]  commit_rd_addr,
  output logic [63:0] commit_rd_data,
  output logic        redirect_valid,
  output logic        halted
);

  state_t      state, nstate;
  logic [63:0] pc, npc_q, rd_data_q;
  logic [31:0] inst;
  logic        rd_wen_q, redir_q, halt_q;
  logic        ld_wait, ld_wait_n;

  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [63:0] rs1v, rs2v, maddr;
  logic        is_ld, is_st, br_take;

  logic [63:0] ex_res, ex_npc;
  logic        ex_wen, ex_redir, ex_halt;

  assign opc = inst[6:0];
  assign rd  = inst[11:7];
  assign f3  = inst[14:12];
  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];

  assign imm_i = {{52{inst[31]}}, inst[31:20]};
  assign imm_s = {{52{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{51{inst[31]}}, inst[31], inst[7],
                  inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {{32{inst[31]}}, inst[31:12], 12'b0};
  assign imm_j = {{43{inst[31]}}, inst[31], inst[19:12],
                  inst[20], inst[30:21], 1'b0};

  dand_regfile u_rf (
    .clk      (clk),
    .reset    (reset),
    .rs1_addr (rs1),
    .rs1_data (rs1v),
    .rs2_addr (rs2),
    .rs2_data (rs2v),
    .wen      (state == WB && rd_wen_q),
    .waddr    (rd),
    .wdata    (rd_data_q)
  );

  assign is_ld = (opc == OP_LOAD);
  assign is_st = (opc == OP_STORE);
  assign maddr = rs1v + (is_st ? imm_s : imm_i);

  always_comb begin
    br_take = 1'b0;
    case (f3)
      3'd0: br_take = (rs1v == rs2v);
      3'd1: br_take = (rs1v != rs2v);
      3'd4: br_take = ($signed(rs1v) < $signed(rs2v));
      3'd5: br_take = ($signed(rs1v) >= $signed(rs2v));
      3'd6: br_take = (rs1v < rs2v);
      3'd7: br_take = (rs1v >= rs2v);
      default: br_take = 1'b0;
    endcase
  end

  // Unknown opcodes fall to default: PC+4, no write
  always_comb begin
    ex_res   = '0;
    ex_wen   = 1'b0;
    ex_npc   = pc + 64'd4;
    ex_redir = 1'b0;
    ex_halt  = 1'b0;
    unique case (1'b1)
      opc == OP_LUI: begin
        ex_res = imm_u;
        ex_wen = 1'b1;
      end
      opc == OP_AUIPC: begin
        ex_res = pc + imm_u;
        ex_wen = 1'b1;
      end
      opc == OP_JAL: begin
        ex_res   = pc + 64'd4;
        ex_wen   = 1'b1;
        ex_npc   = pc + imm_j;
        ex_redir = 1'b1;
      end
      opc == OP_JALR: begin
        ex_res   = pc + 64'd4;
        ex_wen   = 1'b1;
        ex_npc   = (rs1v + imm_i) & ~64'd1;
        ex_redir = 1'b1;
      end
      opc == OP_BRANCH: begin
        if (br_take) begin
          ex_npc   = pc + imm_b;
          ex_redir = 1'b1;
        end
      end
      opc == OP_LOAD: begin
        ex_res = load_ext(dcache_rsp_payload_data,
                          maddr[2:0], f3);
        ex_wen = 1'b1;
      end
      opc == OP_STORE: ;
      opc == OP_IMM: begin
        ex_res = alu_op(f3, f3 == 3'd5 && inst[30],
                        1'b0, rs1v, imm_i);
        ex_wen = 1'b1;
      end
      opc == OP_OP: begin
        ex_res = alu_op(f3, inst[30], 1'b0, rs1v, rs2v);
        ex_wen = 1'b1;
      end
      opc == OP_IMM_32: begin
        ex_res = alu_op(f3, f3 == 3'd5 && inst[30],
                        1'b1, rs1v, imm_i);
        ex_wen = 1'b1;
      end
      opc == OP_32: begin
        ex_res = alu_op(f3, inst[30], 1'b1, rs1v, rs2v);
        ex_wen = 1'b1;
      end
      opc == HALT_OPCODE: ex_halt = 1'b1;
      default: ;
    endcase
    ex_wen = ex_wen && (rd != 5'd0);
  end

  // ld_wait: load accepted without data; cmd stays low until rsp
  assign dcache_cmd_valid = (state == EXEC) && (is_ld || is_st)
                            && !ld_wait;
  assign dcache_cmd_payload_addr  = maddr;
  assign dcache_cmd_payload_wen   = is_st;
  assign dcache_cmd_payload_size  = {1'b0, f3[1:0]};
  assign dcache_cmd_payload_wdata = rs2v << {maddr[2:0], 3'b000};
  assign dcache_cmd_payload_wstrb = lane_strb(f3[1:0], maddr[2:0]);

  always_comb begin
    nstate    = state;
    ld_wait_n = ld_wait;
    unique case (state)
      FETCH: if (icache_cmd_ready) nstate = IWAIT;
      IWAIT: if (icache_rsp_valid) nstate = EXEC;
      EXEC: begin
        if (!(is_ld || is_st)) begin
          nstate = WB;
        end else if (ld_wait) begin
          if (dcache_rsp_valid) begin
            nstate    = WB;
            ld_wait_n = 1'b0;
          end
        end else if (dcache_cmd_ready) begin
          if (is_st || dcache_rsp_valid) nstate = WB;
          else ld_wait_n = 1'b1;
        end
      end
      WB:   nstate = halt_q ? HALT : FETCH;
      HALT: nstate = HALT;
      default: nstate = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      pc        <= PC_START;
      inst      <= '0;
      ld_wait   <= 1'b0;
      npc_q     <= '0;
      rd_data_q <= '0;
      rd_wen_q  <= 1'b0;
      redir_q   <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      state <= nstate;
      if (state == IWAIT && icache_rsp_valid)
        inst <= icache_rsp_payload_data;
      // last EXEC cycle (the one leaving) wins
      if (state == EXEC) begin
        ld_wait   <= ld_wait_n;
        rd_data_q <= ex_res;
        rd_wen_q  <= ex_wen;
        npc_q     <= ex_npc;
        redir_q   <= ex_redir;
        halt_q    <= ex_halt;
      end
      if (state == WB) pc <= npc_q;
    end
  end

  // gated by reset so no request is visible while held in reset
  assign icache_cmd_valid = (state == FETCH) && reset;
  assign icache_cmd_payload_addr = pc;

  assign commit_valid   = (state == WB);
  assign commit_pc      = pc;
  assign commit_inst    = inst;
  assign commit_rd_wen  = (state == WB) && rd_wen_q;
  assign commit_rd_addr = rd;
  assign commit_rd_data = rd_data_q;
  assign redirect_valid = (state == WB) && redir_q;
  assign halted         = (state == HALT);

endmodule

// File: tb/tb_dand_riscv_simple.sv
// Scoreboard bench for dand_riscv_simple.
// Directed program; commits and dcache commands checked by a monitor.
module tb_dand_riscv_simple;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        icache_cmd_valid;
  logic        icache_cmd_ready;
  logic [63:0] icache_cmd_payload_addr;
  logic        icache_rsp_valid;
  logic [31:0] icache_rsp_payload_data;
  logic        dcache_cmd_valid;
  logic        dcache_cmd_ready;
  logic [63:0] dcache_cmd_payload_addr;
  logic        dcache_cmd_payload_wen;
  logic [63:0] dcache_cmd_payload_wdata;
  logic [7:0]  dcache_cmd_payload_wstrb;
  logic [2:0]  dcache_cmd_payload_size;
  logic        dcache_rsp_valid;
  logic [63:0] dcache_rsp_payload_data;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic [31:0] commit_inst;
  logic        commit_rd_wen;
  logic [4:0]  commit_rd_addr;
  logic [63:0] commit_rd_data;
  logic        redirect_valid;
  logic        halted;

  always #5 clk = ~clk;

  dand_riscv_simple dut (
    .clk                      (clk),
    .reset                    (reset),
    .icache_cmd_valid         (icache_cmd_valid),
    .icache_cmd_ready         (icache_cmd_ready),
    .icache_cmd_payload_addr  (icache_cmd_payload_addr),
    .icache_rsp_valid         (icache_rsp_valid),
    .icache_rsp_payload_data  (icache_rsp_payload_data),
    .dcache_cmd_valid         (dcache_cmd_valid),
    .dcache_cmd_ready         (dcache_cmd_ready),
    .dcache_cmd_payload_addr  (dcache_cmd_payload_addr),
    .dcache_cmd_payload_wen   (dcache_cmd_payload_wen),
    .dcache_cmd_payload_wdata (dcache_cmd_payload_wdata),
    .dcache_cmd_payload_wstrb (dcache_cmd_payload_wstrb),
    .dcache_cmd_payload_size  (dcache_cmd_payload_size),
    .dcache_rsp_valid         (dcache_rsp_valid),
    .dcache_rsp_payload_data  (dcache_rsp_payload_data),
    .commit_valid             (commit_valid),
    .commit_pc                (commit_pc),
    .commit_inst              (commit_inst),
    .commit_rd_wen            (commit_rd_wen),
    .commit_rd_addr           (commit_rd_addr),
    .commit_rd_data           (commit_rd_data),
    .redirect_valid           (redirect_valid),
    .halted                   (halted)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        redir;
  } cexp_t;

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [2:0]  size;
  } dexp_t;

  cexp_t       cq[$];
  dexp_t       dq[$];
  logic [31:0] prog [18];
  logic [63:0] dword = 64'h0000_0000_8000_0000;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic ec(input int idx, input logic wen,
                    input logic [4:0] rd,
                    input logic [63:0] data,
                    input logic redir);
    cexp_t e;
    e.pc    = 64'h8000_0000 + 64'(idx * 4);
    e.inst  = prog[idx];
    e.wen   = wen;
    e.rd    = rd;
    e.data  = data;
    e.redir = redir;
    cq.push_back(e);
  endtask

  task automatic ed(input logic [63:0] addr, input logic wen,
                    input logic [63:0] wdata,
                    input logic [7:0] wstrb,
                    input logic [2:0] size);
    dexp_t d;
    d.addr  = addr;
    d.wen   = wen;
    d.wdata = wdata;
    d.wstrb = wstrb;
    d.size  = size;
    dq.push_back(d);
  endtask

  function automatic logic [31:0] fetch(input logic [63:0] a);
    logic [63:0] o;
    o = (a - 64'h8000_0000) >> 2;
    if (o < 64'd18) return prog[o[4:0]];
    return 32'h0000_006b;
  endfunction

  // memory responder: icache 1 cycle, dcache same cycle,
  // except the second load which answers one cycle later
  initial begin : resp
    logic        ipend;
    logic [63:0] ia;
    int          nld;
    logic        dpend;
    ipend = 0; ia = '0; nld = 0; dpend = 0;
    icache_rsp_valid = 0;
    icache_rsp_payload_data = '0;
    dcache_rsp_valid = 0;
    dcache_rsp_payload_data = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        ipend = 0;
        dpend = 0;
        icache_rsp_valid = 0;
        dcache_rsp_valid = 0;
      end else begin
        icache_rsp_valid = ipend;
        icache_rsp_payload_data = fetch(ia);
        ipend = icache_cmd_valid;
        if (icache_cmd_valid) ia = icache_cmd_payload_addr;
        dcache_rsp_valid = 0;
        dcache_rsp_payload_data = dword;
        if (dcache_cmd_valid && !dcache_cmd_payload_wen) begin
          nld++;
          if (nld == 2) dpend = 1;
          else dcache_rsp_valid = 1;
        end else if (dpend) begin
          dcache_rsp_valid = 1;
          dpend = 0;
        end
      end
    end
  end

  initial begin : mon
    cexp_t e;
    dexp_t d;
    forever begin
      @(negedge clk);
      if (reset && commit_valid) begin
        if (cq.size() == 0) begin
          chk("commit_extra_pc", commit_pc, '1);
        end else begin
          e = cq.pop_front();
          chk("commit_pc", commit_pc, e.pc);
          chk("commit_inst", commit_inst, e.inst);
          chk("commit_rd_wen", commit_rd_wen, e.wen);
          chk("redirect", redirect_valid, e.redir);
          if (e.wen) begin
            chk("commit_rd", commit_rd_addr, e.rd);
            chk("commit_data", commit_rd_data, e.data);
          end
        end
      end
      if (reset && dcache_cmd_valid && dcache_cmd_ready) begin
        if (dq.size() == 0) begin
          chk("dcache_extra", dcache_cmd_payload_addr, '1);
        end else begin
          d = dq.pop_front();
          chk("d_addr", dcache_cmd_payload_addr, d.addr);
          chk("d_wen", dcache_cmd_payload_wen, d.wen);
          chk("d_size", dcache_cmd_payload_size, d.size);
          if (d.wen) begin
            chk("d_wdata", dcache_cmd_payload_wdata, d.wdata);
            chk("d_wstrb", dcache_cmd_payload_wstrb, d.wstrb);
          end
        end
      end
    end
  end

  initial begin
    icache_cmd_ready = 1;
    dcache_cmd_ready = 1;

    prog[0]  = 32'hFFF0_0093; // addi x1,x0,-1
    prog[1]  = 32'h0040_D11B; // srliw x2,x1,4
    prog[2]  = 32'h8000_11B7; // lui x3,0x80001
    prog[3]  = 32'h0201_9193; // slli x3,x3,32
    prog[4]  = 32'h0000_0463; // beq x0,x0,+8
    prog[5]  = 32'h0010_0493; // addi x9,x0,1 (skipped)
    prog[6]  = 32'h0201_D193; // srli x3,x3,32
    prog[7]  = 32'h0011_82A3; // sb x1,5(x3)
    prog[8]  = 32'h0031_8203; // lb x4,3(x3)
    prog[9]  = 32'h0031_C283; // lbu x5,3(x3)
    prog[10] = 32'h0000_1463; // bne x0,x0,+8
    prog[11] = 32'h0050_0013; // addi x0,x0,5
    prog[12] = 32'h4011_0333; // sub x6,x2,x1
    prog[13] = 32'h0080_03EF; // jal x7,+8
    prog[14] = 32'h0010_0493; // addi x9,x0,1 (skipped)
    prog[15] = 32'h0000_A433; // slt x8,x1,x0
    prog[16] = 32'h0021_B423; // sd x2,8(x3)
    prog[17] = 32'h0000_006B; // halt

    ec(0,  1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    ec(1,  1, 2, 64'h0000_0000_0FFF_FFFF, 0);
    ec(2,  1, 3, 64'hFFFF_FFFF_8000_1000, 0);
    ec(3,  1, 3, 64'h8000_1000_0000_0000, 0);
    ec(4,  0, 0, 64'h0, 1);
    ec(6,  1, 3, 64'h0000_0000_8000_1000, 0);
    ec(7,  0, 0, 64'h0, 0);
    ec(8,  1, 4, 64'hFFFF_FFFF_FFFF_FF80, 0);
    ec(9,  1, 5, 64'h0000_0000_0000_0080, 0);
    ec(10, 0, 0, 64'h0, 0);
    ec(11, 0, 0, 64'h0, 0);
    ec(12, 1, 6, 64'h0000_0000_1000_0000, 0);
    ec(13, 1, 7, 64'h0000_0000_8000_0038, 1);
    ec(15, 1, 8, 64'h1, 0);
    ec(16, 0, 0, 64'h0, 0);
    ec(17, 0, 0, 64'h0, 0);

    ed(64'h8000_1005, 1, 64'hFFFF_FF00_0000_0000, 8'h20, 3'd0);
    ed(64'h8000_1003, 0, 64'h0, 8'h0, 3'd0);
    ed(64'h8000_1003, 0, 64'h0, 8'h0, 3'd0);
    ed(64'h8000_1008, 1, 64'h0000_0000_0FFF_FFFF, 8'hFF, 3'd3);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_icache_valid", icache_cmd_valid, 0);
    chk("rst_dcache_valid", dcache_cmd_valid, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_redirect", redirect_valid, 0);
    chk("rst_halted", halted, 0);

    @(posedge clk);
    #2 reset = 1;
    #1;
    chk("fetch_valid", icache_cmd_valid, 1);
    chk("fetch_addr", icache_cmd_payload_addr, 64'h8000_0000);

    for (int i = 0; i < 2000 && !halted; i++) @(posedge clk);
    #1;
    chk("halted", halted, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 chk("halt_no_fetch", icache_cmd_valid, 0);
    end
    chk("commits_left", 64'(cq.size()), 0);
    chk("dcache_left", 64'(dq.size()), 0);
    chk("x0_zero", dut.u_rf.reg_file_0, 0);
    chk("x9_untouched", dut.u_rf.reg_file_9, 0);
    chk("x5_lbu", dut.u_rf.reg_file_5, 64'h80);

    reset = 0;
    #1;
    chk("rst2_halted", halted, 0);
    chk("rst2_icache_valid", icache_cmd_valid, 0);
    chk("rst2_x1", dut.u_rf.reg_file_1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
